// File: rtl/within_gen_pkg.sv
// rtl/within_gen_pkg.sv - shared FSM state type and window-length helper
package within_gen_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int win_len(input int a_len, input int gap, input int b_len);
    return a_len + gap + b_len;
  endfunction

endpackage

// File: rtl/within_window_gen_pulse_train.sv
// rtl/within_window_gen_pulse_train.sv - burst of count one-cycle pulses spaced two cycles apart
module pulse_train #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trigger,
  input  logic [CW-1:0] count,
  output logic          pulse
);

  localparam logic [CW-1:0] ONE = 1;

  logic [CW-1:0] rem_q;
  logic          gap_q;

  // The caller decodes trigger one cycle early, so the registered first pulse
  // lands on the cycle the caller aimed for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      gap_q <= 1'b0;
      pulse <= 1'b0;
    end else if (trigger && count != '0) begin
      pulse <= 1'b1;
      rem_q <= count - ONE;
      gap_q <= 1'b1;
    end else if (gap_q) begin
      pulse <= 1'b0;
      gap_q <= 1'b0;
    end else if (rem_q != '0) begin
      pulse <= 1'b1;
      rem_q <= rem_q - ONE;
      gap_q <= 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/within_window_gen.sv
// rtl/within_window_gen.sv - reference window a/b plus c/d test sequence generator
module within_window_gen
  import within_gen_pkg::*;
#(
  parameter int A_LEN     = 4,
  parameter int GAP       = 2,
  parameter int B_LEN     = 2,
  parameter int C_CNT     = 2,
  parameter int D_CNT     = 2,
  parameter int CW        = 5,
  parameter int C_OFF_MAX = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] c_off,
  input  logic          overrun,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          d,
  output logic          in_window,
  output logic          busy,
  output logic          done,
  output logic          fits
);

  localparam int W       = win_len(A_LEN, GAP, B_LEN);
  localparam int MAX_END = C_OFF_MAX + 2 * (C_CNT + D_CNT + 1) - 2;

  localparam logic [CW-1:0] W_LAST     = CW'(W - 1);
  localparam logic [CW-1:0] A_END      = CW'(A_LEN);
  localparam logic [CW-1:0] B_BEGIN    = CW'(A_LEN + GAP);
  localparam logic [CW-1:0] W_END      = CW'(W);
  localparam logic [CW-1:0] D_OFF      = CW'(2 * C_CNT);
  localparam logic [CW-1:0] LASTD_BASE = CW'(2 * (C_CNT + D_CNT) - 2);
  localparam logic [CW-1:0] C_COUNT    = CW'(C_CNT);
  localparam logic [CW-1:0] D_COUNT    = CW'(D_CNT);
  localparam logic [CW-1:0] ONE        = 1;

  if (MAX_END > (1 << CW) - 1 || W > (1 << CW) - 1) begin : g_cfg_check
    $error("within_window_gen: CW too narrow for the largest end index");
  end

  state_t        state_q, state_nxt;
  logic [CW-1:0] k_q, k_nxt, end_q, c_off_q;
  logic          overrun_q;
  logic          accept, run_nxt, ov_eff, c_trig, d_trig;
  logic [CW-1:0] c_off_eff, lastd, end_calc, d_count;

  assign accept    = (state_q == IDLE) && start;
  assign c_off_eff = accept ? c_off : c_off_q;
  assign ov_eff    = accept ? overrun : overrun_q;
  assign lastd     = c_off + LASTD_BASE + {{(CW-2){1'b0}}, overrun, 1'b0};
  assign end_calc  = (lastd > W_LAST) ? lastd : W_LAST;
  assign d_count   = D_COUNT + {{(CW-1){1'b0}}, ov_eff};

  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          k_nxt     = '0;
        end
      end
      RUN: begin
        if (k_q == end_q) begin
          state_nxt = DONE;
          k_nxt     = '0;
        end else begin
          k_nxt = k_q + ONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next index so they line up with k in the same cycle.
  assign run_nxt = (state_nxt == RUN);
  assign c_trig  = run_nxt && (k_nxt == c_off_eff);
  assign d_trig  = run_nxt && (k_nxt == c_off_eff + D_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      end_q     <= '0;
      c_off_q   <= '0;
      overrun_q <= 1'b0;
      fits      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      in_window <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      k_q       <= k_nxt;
      if (accept) begin
        end_q     <= end_calc;
        c_off_q   <= c_off;
        overrun_q <= overrun;
        fits      <= (lastd <= W_LAST);
      end
      a         <= run_nxt && (k_nxt < A_END);
      b         <= run_nxt && (k_nxt >= B_BEGIN) && (k_nxt < W_END);
      in_window <= run_nxt && (k_nxt < W_END);
      busy      <= run_nxt;
      done      <= (state_nxt == DONE);
    end
  end

  pulse_train #(.CW(CW)) u_c_train (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (c_trig),
    .count   (C_COUNT),
    .pulse   (c)
  );

  pulse_train #(.CW(CW)) u_d_train (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (d_trig),
    .count   (d_count),
    .pulse   (d)
  );

endmodule

// File: tb/tb_within_window_gen.sv
// tb/tb_within_window_gen.sv - scoreboard bench for within_window_gen
module tb_within_window_gen;

  localparam int A_LEN = 4;
  localparam int GAP   = 2;
  localparam int B_LEN = 2;
  localparam int C_CNT = 2;
  localparam int D_CNT = 2;
  localparam int CW    = 5;
  localparam int W     = A_LEN + GAP + B_LEN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] c_off = '0;
  logic          overrun = 1'b0;
  logic          a, b, c, d, in_window, busy, done, fits;

  int tests = 0;
  int fails = 0;

  // {a, b, c, d, in_window, busy, done, fits}
  logic [7:0] exp_q[$];
  logic       fits_hold = 1'b0;

  within_window_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_off     (c_off),
    .overrun   (overrun),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_window (in_window),
    .busy      (busy),
    .done      (done),
    .fits      (fits)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {a, b, c, d, in_window, busy, done, fits};
  endfunction

  // Reference: enumerate each window cycle from the pulse/window rules.
  function automatic int push_window(input int co, input int ov, output logic f);
    int dn, lastd, endk, n;
    logic ea, eb, ec, ed, ew;
    dn    = D_CNT + ov;
    lastd = co + 2 * (C_CNT + dn) - 2;
    endk  = (lastd > W - 1) ? lastd : W - 1;
    f     = (lastd <= W - 1);
    n     = 0;
    for (int k = 0; k <= endk; k++) begin
      ea = (k < A_LEN);
      eb = (k >= A_LEN + GAP) && (k < W);
      ew = (k < W);
      ec = 1'b0;
      ed = 1'b0;
      for (int i = 0; i < C_CNT; i++) if (k == co + 2 * i) ec = 1'b1;
      for (int j = 0; j < dn; j++) if (k == co + 2 * C_CNT + 2 * j) ed = 1'b1;
      exp_q.push_back({ea, eb, ec, ed, ew, 1'b1, 1'b0, f});
      n++;
    end
    exp_q.push_back({7'b0000001, f});
    return n + 1;
  endfunction

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        fits_hold = e[0];
      end else begin
        e = {7'b0, fits_hold};
      end
      tests++;
      if (outs() !== e) begin
        fails++;
        $display("FAIL cycle t=%0t got abcd_w_busy_done_fits=%b expected=%b", $time, outs(), e);
      end
    end
  end

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (i == 400) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic one_window(input int co, input int ov);
    int   n;
    logic f;
    drain();
    #1;
    c_off   = CW'(co);
    overrun = ov[0];
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = push_window(co, ov, f);
    c_off = CW'($urandom_range(0, 23));
  endtask

  initial begin
    int   n1, n2;
    logic f1, f2;

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (outs() !== 8'h00) begin
      fails++;
      $display("FAIL reset_state got=%b expected=%b", outs(), 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    one_window(1, 0);
    one_window(1, 1);
    one_window(9, 0);
    one_window(23, 1);
    one_window(0, 1);

    // Start held through RUN and DONE; c_off changes mid-run for the second window.
    drain();
    #1;
    c_off   = 5'd0;
    overrun = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    n1 = push_window(0, 0, f1);
    exp_q.push_back({7'b0, f1});
    c_off   = 5'd3;
    overrun = 1'b1;
    n2 = push_window(3, 1, f2);
    repeat (n1 + 1) @(posedge clk);
    #1;
    start = 1'b0;

    // Asynchronous reset in the middle of a window.
    one_window(2, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (outs() !== 8'h00) begin
      fails++;
      $display("FAIL async_reset got=%b expected=%b", outs(), 8'h00);
    end
    exp_q.delete();
    fits_hold = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    one_window(1, 0);

    for (int r = 0; r < 14; r++) one_window($urandom_range(0, 23), $urandom_range(0, 1));

    drain();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
